// File: rtl/pwm_sample_modulator.sv
// PWM output stage: 2-entry sample FIFO feeding one duty value per 2**SAMPLE_W-cycle period.
// Optional macro AUDIO_PWM_DSM_EN swaps the counter compare for a first-order delta-sigma modulator.
module pwm_sample_modulator #(
  parameter int SAMPLE_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                pwm,
  output logic                period_start,
  output logic                underrun,
  output logic [7:0]          underrun_cnt,
  input  logic                clear
);

  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
  localparam logic [SAMPLE_W-1:0] DUTY_RST = {1'b1, {(SAMPLE_W-1){1'b0}}};

  logic [SAMPLE_W-1:0] cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] duty_q, duty_d;
  logic [SAMPLE_W-1:0] fifo0_q, fifo1_q, fifo_head;
  logic                wr_ptr_q, rd_ptr_q;
  logic [1:0]          level_q, level_d;
  logic                pwm_q, pwm_d;
  logic                period_start_q, period_start_d;
  logic                underrun_q, underrun_d;
  logic [7:0]          underrun_cnt_q, underrun_cnt_d;
  logic                push, pop, boundary;

  assign sample_ready = (level_q != 2'd2);
  assign pwm          = pwm_q;
  assign period_start = period_start_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign fifo_head    = rd_ptr_q ? fifo1_q : fifo0_q;

  // A pop against an empty FIFO is an underrun even if a push lands the same cycle (no bypass).
  always_comb begin
    push           = sample_valid && sample_ready;
    boundary       = enable && (cnt_q == CNT_MAX);
    pop            = boundary && (level_q != 2'd0);
    underrun_d     = boundary && (level_q == 2'd0);
    duty_d         = pop ? fifo_head : duty_q;
    cnt_d          = enable ? cnt_q + 1'b1 : '0;
    period_start_d = enable && (cnt_q == '0);
    level_d        = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 2'd1;
      2'b01:   level_d = level_q - 2'd1;
      default: level_d = level_q;
    endcase
    underrun_cnt_d = underrun_cnt_q;
    if (clear) begin
      underrun_cnt_d = 8'd0;
    end else if (underrun_d && (underrun_cnt_q != 8'hFF)) begin
      underrun_cnt_d = underrun_cnt_q + 8'd1;
    end
  end

`ifdef AUDIO_PWM_DSM_EN
  logic [SAMPLE_W:0] acc_q, acc_d, acc_sum;

  // Carry out of the low bits is the density bit; only the low bits carry into the next cycle.
  always_comb begin
    acc_sum = {1'b0, acc_q[SAMPLE_W-1:0]} + {1'b0, duty_q};
    acc_d   = enable ? acc_sum : '0;
    pwm_d   = enable && acc_sum[SAMPLE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  always_comb begin
    pwm_d = enable && (cnt_q < duty_q);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q          <= '0;
      duty_q         <= DUTY_RST;
      fifo0_q        <= '0;
      fifo1_q        <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      level_q        <= 2'd0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= 8'd0;
    end else begin
      cnt_q          <= cnt_d;
      duty_q         <= duty_d;
      level_q        <= level_d;
      pwm_q          <= pwm_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      wr_ptr_q       <= wr_ptr_q ^ push;
      rd_ptr_q       <= rd_ptr_q ^ pop;
      if (push && !wr_ptr_q) fifo0_q <= sample_in;
      if (push && wr_ptr_q)  fifo1_q <= sample_in;
    end
  end

endmodule

// File: tb/tb_pwm_sample_modulator.sv
// Scoreboard bench for pwm_sample_modulator: queue-based reference model, per-cycle and per-period checks.
module tb_pwm_sample_modulator;
  localparam int W = 8;
  localparam int P = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic         sample_valid = 1'b0;
  logic         clear = 1'b0;
  logic         sample_ready, pwm, period_start, underrun;
  logic [7:0]   underrun_cnt;

  always #5 clk = ~clk;

  pwm_sample_modulator #(.SAMPLE_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .pwm(pwm),
    .period_start(period_start), .underrun(underrun),
    .underrun_cnt(underrun_cnt), .clear(clear)
  );

  typedef struct {
    bit pwm;
    bit ps;
    bit ur;
    bit rdy;
    int ucnt;
  } exp_t;

  exp_t exp_q[$];
  int   per_q[$];
  int   mq[$];
  int   m_phase, m_duty, m_ucnt, m_acc;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model: each period plays the duty popped at its start; an empty FIFO keeps the old duty.
  int  o_phase, o_duty, s;
  bit  en, full, ur, pw, ps;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_duty = P / 2; m_ucnt = 0; m_acc = 0;
      mq.delete(); exp_q.delete(); per_q.delete();
    end else begin
      o_phase = m_phase;
      o_duty  = m_duty;
      en      = enable;
      full    = (mq.size() == 2);
      ur      = 1'b0;
      if (en && o_phase == P - 1) begin
        if (mq.size() > 0) m_duty = mq.pop_front();
        else ur = 1'b1;
      end
      if (sample_valid && !full) mq.push_back(int'(sample_in));
      if (clear) m_ucnt = 0;
      else if (ur && m_ucnt < 255) m_ucnt++;
`ifdef AUDIO_PWM_DSM_EN
      if (en) begin
        s     = (m_acc % P) + o_duty;
        pw    = (s >= P);
        m_acc = s;
      end else begin
        pw    = 1'b0;
        m_acc = 0;
      end
`else
      pw = en && (o_phase < o_duty);
`endif
      ps = en && (o_phase == 0);
      if (ps) per_q.push_back(o_duty);
      m_phase = en ? (o_phase + 1) % P : 0;
      exp_q.push_back('{pwm: pw, ps: ps, ur: ur, rdy: (mq.size() < 2), ucnt: m_ucnt});
    end
  end

  // Monitor: per-cycle compare plus high-cycle count over every complete enabled period.
  exp_t e;
  bit   have_win = 1'b0;
  int   win_len, win_high, win_duty;
  always @(negedge clk) begin
    if (!rst_n) begin
      have_win = 1'b0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pwm", pwm, e.pwm);
      check("period_start", period_start, e.ps);
      check("underrun", underrun, e.ur);
      check("underrun_cnt", underrun_cnt, e.ucnt);
      check("sample_ready", sample_ready, e.rdy);
      if (period_start === 1'b1) begin
        if (have_win && win_len == P) check("period_high_count", win_high, win_duty);
        have_win = (per_q.size() > 0);
        if (have_win) win_duty = per_q.pop_front();
        win_len  = 0;
        win_high = 0;
      end
      win_len++;
      if (pwm === 1'b1) win_high++;
      if (!enable) have_win = 1'b0;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_sample(input int v);
    bit acc;
    int t = 0;
    sample_in    = v[W-1:0];
    sample_valid = 1'b1;
    do begin
      acc = sample_ready;
      @(negedge clk);
      t++;
    end while (!acc && t < 4 * P);
    sample_valid = 1'b0;
    if (!acc) timeout_fail("push_sample");
  endtask

  task automatic wait_phase(input int target);
    int t = 0;
    while (m_phase != target && t < 2 * P) begin
      @(negedge clk);
      t++;
    end
    if (m_phase != target) timeout_fail("wait_phase");
  endtask

  initial begin
    int t;
    cycles(3);
    check("reset_pwm", pwm, 0);
    check("reset_period_start", period_start, 0);
    check("reset_underrun", underrun, 0);
    check("reset_underrun_cnt", underrun_cnt, 0);
    check("reset_sample_ready", sample_ready, 1);
    rst_n  = 1'b1;
    enable = 1'b1;

    cycles(3 * P);                       // no samples: midscale duty, underrun each period

    push_sample(64);
    push_sample(192);
    cycles(4 * P);

    push_sample(10);                     // valid held: third accept waits for a pop
    push_sample(20);
    push_sample(30);
    cycles(5 * P);

    push_sample(0);
    push_sample(255);
    cycles(2 * P + 100);
    enable = 1'b0;
    cycles(1);
    check("pwm_after_disable", pwm, 0);
    cycles(20);
    enable = 1'b1;
    cycles(3 * P);

    t = 0;
    while (m_ucnt < 255 && t < 300 * P) begin
      @(negedge clk);
      t++;
    end
    if (m_ucnt < 255) timeout_fail("saturation_wait");
    cycles(3 * P);
    check("ucnt_saturated", underrun_cnt, 255);

    wait_phase(P - 1);                   // clear lands on the underrun edge
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_same_cycle_cnt", underrun_cnt, 0);
    check("clear_same_cycle_pulse", underrun, 1);
    cycles(2 * P);

    for (int i = 0; i < 4000; i++) begin
      sample_valid = ($urandom_range(3) == 0);
      sample_in    = W'($urandom);
      clear        = ($urandom_range(299) == 0);
      if ($urandom_range(499) == 0) enable = ~enable;
      @(negedge clk);
    end
    sample_valid = 1'b0;
    clear        = 1'b0;
    enable       = 1'b1;

    push_sample(200);
    cycles(3 * P);
    wait_phase(50);
    check("pwm_before_reset", pwm, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_pwm", pwm, 0);
    check("midreset_sample_ready", sample_ready, 1);
    check("midreset_underrun_cnt", underrun_cnt, 0);
    check("midreset_period_start", period_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3 * P);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
